s2mm_packet_arbiter: RTL and testbench
======================================

Name: s2mm_packet_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single MCDMA S2MM AXI-Stream slave port between NUM_CHANNELS first-word-fall-through accelerator FIFOs.
- A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved.
- Each packet is tagged with tdest = channel index.
- It drives a registered, backpressure-safe AXIS output.
- It enforces a maximum packet length and reports sticky truncation errors to the control register block.

Parameters:
- AXIS_DATA_WIDTH, 32, output stream data width.
- FIFO_DATA_WIDTH, 32, per-channel FIFO word width. Must be ≤ AXIS_DATA_WIDTH; the word is zero-extended.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- AXIS_DEST_WIDTH, 4, tdest width. Must satisfy NUM_CHANNELS ≤ 2**AXIS_DEST_WIDTH.
- NUM_CHANNELS, 2, number of FIFO requesters. Must be ≥ 2.
- MAX_PKT_BEATS, 1024, beat limit per packet. Must be ≥ 2.

Ports:
- clk_in, input, 1: system clock.
- rst_n_in, input, 1: asynchronous, active-low reset.
- SINK_AXIS_tready_in, input, 1: MCDMA S2MM ready.
- SINK_AXIS_tdata_out, output, AXIS_DATA_WIDTH: beat data.
- SINK_AXIS_tdest_out, output, AXIS_DEST_WIDTH: source channel index.
- SINK_AXIS_tkeep_out, output, AXIS_KEEP_WIDTH: all ones.
- SINK_AXIS_tlast_out, output, 1: packet end.
- SINK_AXIS_tuser_out, output, 1: constant 0.
- SINK_AXIS_tvalid_out, output, 1: beat valid.
- fifo_data_in, input, NUM_CHANNELS*FIFO_DATA_WIDTH: packed FWFT heads; channel i occupies slice [i*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH].
- fifo_not_empty_in, input, NUM_CHANNELS: per-channel data available.
- fifo_last_in, input, NUM_CHANNELS: head word is the last word of its packet.
- fifo_r_stb_out, output, NUM_CHANNELS: one-hot pop strobe, at most one bit set per cycle.
- chan_en_in, input, NUM_CHANNELS: channel arbitration enable mask.
- trunc_clr_in, input, NUM_CHANNELS: write-1-to-clear pulse for trunc_err_out.
- grant_out, output, NUM_CHANNELS: one-hot current grant; 0 when no grant is held.
- busy_out, output, 1: high while in XFER.
- pkt_done_out, output, 1: one-cycle pulse when a tlast beat is popped.
- trunc_err_out, output, NUM_CHANNELS: sticky truncation flag per channel.

Behaviour:
- Reset: rst_n_in low asynchronously clears all state.
  - tvalid, tlast, tdata, tdest, fifo_r_stb, grant, busy, pkt_done and trunc_err all go to 0.
  - State returns to IDLE.
  - rr_ptr is set to NUM_CHANNELS-1, so channel 0 has first priority.
  - Reset mid-packet drops the partial packet; no recovery is attempted.
- States:
  - IDLE: enters ARB when req = chan_en_in & fifo_not_empty_in is nonzero.
  - ARB: picks the first set req bit searching upward from rr_ptr+1 with wrap. It registers the grant, clears beat_cnt and enters XFER the next cycle. If req dropped to 0, it returns to IDLE.
  - XFER: pops beats from the granted channel.
- Pop condition in XFER: pop = fifo_not_empty_in[g] & (!tvalid | tready).
  - fifo_r_stb_out[g] = pop, driven combinationally from registered state.
  - An empty granted FIFO mid-packet stalls the grant. The grant is not released and other channels wait.
- Output register: on pop, load tdata, tdest = g, tlast = eff_last, and set tvalid=1. If tready is high without a pop, clear tvalid.
  - Latency from pop to tvalid is 1 cycle.
  - Throughput within a packet is 1 beat per cycle.
- eff_last = fifo_last_in[g] | (beat_cnt == MAX_PKT_BEATS-1).
  - beat_cnt is clog2(MAX_PKT_BEATS) bits and increments per pop.
- Forced truncation: on a pop where eff_last=1 and fifo_last_in[g]=0, set trunc_err_out[g]. The remaining source words form a new packet under a later grant.
- Packet end: a pop with eff_last=1 pulses pkt_done_out, sets rr_ptr = g and moves to ARB. This gives one bubble cycle between packets.
- The last beat may still be waiting for tready while ARB runs. No new pop can occur until that register drains.
- chan_en_in changes affect only the next ARB. Deasserting the granted channel's enable mid-packet does not abort the packet.
- trunc_err: if set and clear occur in the same cycle for the same bit, set wins.
- Single requester: that channel is re-granted after each packet, with a 1-cycle gap.

Decomposition:
- Package s2mm_arb_pkg holds:
  - state enum (IDLE, ARB, XFER);
  - a function for the beat counter width;
  - a parameter-check macro or constants.
- Sub-module s2mm_rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs one-hot gnt, index and any. It is instantiated once.

Test Plan:
- Ch0 only, 4-word packet (last on word 4), tready=1 → 4 beats on consecutive cycles, tdest=0, tlast on beat 4, one pkt_done pulse.
- Ch0 and ch1 both hold 3-word packets from reset → ch0 packet completes first, then 1 idle cycle, then the ch1 packet; no interleaving; tdest 0,0,0,1,1,1.
- tready toggles 1,0,0,1 mid-packet → held beat is stable while tready=0; pop strobes occur only when the register can accept; no beat lost or duplicated.
- MAX_PKT_BEATS=4, ch1 sends 6 words with last on word 6 → beat 4 has tlast=1 and trunc_err_out[1]=1; words 5-6 arrive as a second packet; trunc_clr_in[1] pulse clears the flag.
- chan_en_in=2'b10 with both FIFOs non-empty → only ch1 is granted. Clearing chan_en_in[1] mid-packet → the packet still completes.
- rst_n_in asserted mid-packet → all outputs 0 immediately (asynchronous); after release, arbitration restarts at ch0.

Source files
------------

// File: rtl/s2mm_arb_pkg.sv
// Shared types and helpers for the S2MM packet arbiter.
package s2mm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Width of a counter able to hold 0 .. beats-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Legal parameter combinations for the arbiter.
  function automatic bit params_ok(input int unsigned axis_dw,
                                   input int unsigned fifo_dw,
                                   input int unsigned dest_w,
                                   input int unsigned num_ch,
                                   input int unsigned max_beats);
    return (fifo_dw <= axis_dw) && (num_ch >= 2) &&
           (num_ch <= (32'd1 << dest_w)) && (max_beats >= 2);
  endfunction

endpackage

// File: rtl/s2mm_rr_pick.sv
// Combinational round-robin picker: first set req bit above rr_ptr, with wrap.
module s2mm_rr_pick
  import s2mm_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan rr_ptr+1 .. rr_ptr+N (mod N); the first requester found wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(rr_ptr) + i) % N);
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s2mm_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding the MCDMA S2MM AXI-Stream port
// from NUM_CHANNELS FWFT FIFOs, with a beat limit and sticky truncation flags.
module s2mm_packet_arbiter
  import s2mm_arb_pkg::*;
#(
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DATA_WIDTH = 32,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_DEST_WIDTH = 4,
  parameter int unsigned NUM_CHANNELS    = 2,
  parameter int unsigned MAX_PKT_BEATS   = 1024
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    SINK_AXIS_tready_in,
  output logic [AXIS_DATA_WIDTH-1:0]              SINK_AXIS_tdata_out,
  output logic [AXIS_DEST_WIDTH-1:0]              SINK_AXIS_tdest_out,
  output logic [AXIS_KEEP_WIDTH-1:0]              SINK_AXIS_tkeep_out,
  output logic                                    SINK_AXIS_tlast_out,
  output logic                                    SINK_AXIS_tuser_out,
  output logic                                    SINK_AXIS_tvalid_out,
  input  logic [NUM_CHANNELS*FIFO_DATA_WIDTH-1:0] fifo_data_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_not_empty_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_last_in,
  output logic [NUM_CHANNELS-1:0]                 fifo_r_stb_out,
  input  logic [NUM_CHANNELS-1:0]                 chan_en_in,
  input  logic [NUM_CHANNELS-1:0]                 trunc_clr_in,
  output logic [NUM_CHANNELS-1:0]                 grant_out,
  output logic                                    busy_out,
  output logic                                    pkt_done_out,
  output logic [NUM_CHANNELS-1:0]                 trunc_err_out
);

  localparam int unsigned   IW       = $clog2(NUM_CHANNELS);
  localparam int unsigned   CW       = cnt_width(MAX_PKT_BEATS);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT_BEATS - 1);

  if (!params_ok(AXIS_DATA_WIDTH, FIFO_DATA_WIDTH, AXIS_DEST_WIDTH,
                 NUM_CHANNELS, MAX_PKT_BEATS)) begin : g_param_check
    $error("s2mm_packet_arbiter: illegal parameter combination");
  end

  state_t                      state, state_nxt;
  logic [IW-1:0]               g_idx;
  logic [IW-1:0]               rr_ptr;
  logic [NUM_CHANNELS-1:0]     grant_q;
  logic [CW-1:0]               beat_cnt;
  logic [NUM_CHANNELS-1:0]     req;
  logic [NUM_CHANNELS-1:0]     pick_gnt;
  logic [IW-1:0]               pick_idx;
  logic                        pick_any;
  logic                        pop;
  logic                        eff_last;
  logic                        head_last;
  logic [AXIS_DATA_WIDTH-1:0]  head_data;
  logic                        tvalid_q;
  logic                        tlast_q;
  logic [AXIS_DATA_WIDTH-1:0]  tdata_q;
  logic [AXIS_DEST_WIDTH-1:0]  tdest_q;
  logic                        pkt_done_q;
  logic [NUM_CHANNELS-1:0]     trunc_err_q;

  assign req = chan_en_in & fifo_not_empty_in;

  s2mm_rr_pick #(
    .N  (NUM_CHANNELS),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // State register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic: a grant is held from first beat until the eff_last pop.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|req) state_nxt = ARB;
      ARB:     state_nxt = pick_any ? XFER : IDLE;
      XFER:    if (pop && eff_last) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/pop decode from registered state and the granted FIFO head.
  always_comb begin
    head_data                        = '0;
    head_data[FIFO_DATA_WIDTH-1:0]   = fifo_data_in[g_idx*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
    head_last                        = fifo_last_in[g_idx];
    eff_last                         = head_last | (beat_cnt == LAST_CNT);
    pop            = (state == XFER) && fifo_not_empty_in[g_idx] &&
                     (!tvalid_q || SINK_AXIS_tready_in);
    fifo_r_stb_out = '0;
    if (pop) fifo_r_stb_out[g_idx] = 1'b1;
    grant_out      = (state == XFER) ? grant_q : '0;
    busy_out       = (state == XFER);
  end

  // Grant bookkeeping: capture the pick in ARB, count beats, advance rr_ptr at packet end.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      g_idx    <= '0;
      grant_q  <= '0;
      beat_cnt <= '0;
      rr_ptr   <= IW'(NUM_CHANNELS - 1);
    end else begin
      if (state == ARB && pick_any) begin
        g_idx    <= pick_idx;
        grant_q  <= pick_gnt;
        beat_cnt <= '0;
      end else if (pop) begin
        beat_cnt <= beat_cnt + CW'(1);
        if (eff_last) rr_ptr <= g_idx;
      end
    end
  end

  // AXIS output register: load on pop, drop valid once accepted without a refill.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tdest_q  <= '0;
    end else if (pop) begin
      tvalid_q <= 1'b1;
      tlast_q  <= eff_last;
      tdata_q  <= head_data;
      tdest_q  <= AXIS_DEST_WIDTH'(g_idx);
    end else if (SINK_AXIS_tready_in) begin
      tvalid_q <= 1'b0;
    end
  end

  // Status: packet-done pulse and sticky truncation flags (set beats clear).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pkt_done_q  <= 1'b0;
      trunc_err_q <= '0;
    end else begin
      pkt_done_q  <= pop && eff_last;
      trunc_err_q <= (trunc_err_q & ~trunc_clr_in) |
                     ((pop && eff_last && !head_last) ? grant_q : '0);
    end
  end

  assign SINK_AXIS_tdata_out  = tdata_q;
  assign SINK_AXIS_tdest_out  = tdest_q;
  assign SINK_AXIS_tkeep_out  = '1;
  assign SINK_AXIS_tlast_out  = tlast_q;
  assign SINK_AXIS_tuser_out  = 1'b0;
  assign SINK_AXIS_tvalid_out = tvalid_q;
  assign pkt_done_out         = pkt_done_q;
  assign trunc_err_out        = trunc_err_q;

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// Scoreboard bench for s2mm_packet_arbiter: FWFT FIFO models feed the DUT,
// expected beats are queued when packets are loaded and checked on handshake.
module tb_s2mm_packet_arbiter;

  localparam int unsigned ADW  = 32;
  localparam int unsigned FW   = 16;
  localparam int unsigned KW   = ADW / 8;
  localparam int unsigned DW   = 4;
  localparam int unsigned NCH  = 2;
  localparam int unsigned MAXB = 4;

  typedef struct packed {
    logic          last;
    logic [FW-1:0] data;
  } word_t;

  typedef struct packed {
    logic [ADW-1:0] data;
    logic [DW-1:0]  dest;
    logic           last;
  } beat_t;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              tready = 1'b1;
  logic [ADW-1:0]    tdata;
  logic [DW-1:0]     tdest;
  logic [KW-1:0]     tkeep;
  logic              tlast, tuser, tvalid;
  logic [NCH*FW-1:0] fifo_data_in = '0;
  logic [NCH-1:0]    fifo_not_empty_in = '0;
  logic [NCH-1:0]    fifo_last_in = '0;
  logic [NCH-1:0]    fifo_r_stb_out;
  logic [NCH-1:0]    chan_en_in = '1;
  logic [NCH-1:0]    trunc_clr_in = '0;
  logic [NCH-1:0]    grant_out;
  logic              busy_out, pkt_done_out;
  logic [NCH-1:0]    trunc_err_out;

  word_t       fq0[$];
  word_t       fq1[$];
  beat_t       exp_q[$];
  int unsigned acc_cyc[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH (ADW),
    .FIFO_DATA_WIDTH (FW),
    .AXIS_KEEP_WIDTH (KW),
    .AXIS_DEST_WIDTH (DW),
    .NUM_CHANNELS    (NCH),
    .MAX_PKT_BEATS   (MAXB)
  ) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .SINK_AXIS_tready_in  (tready),
    .SINK_AXIS_tdata_out  (tdata),
    .SINK_AXIS_tdest_out  (tdest),
    .SINK_AXIS_tkeep_out  (tkeep),
    .SINK_AXIS_tlast_out  (tlast),
    .SINK_AXIS_tuser_out  (tuser),
    .SINK_AXIS_tvalid_out (tvalid),
    .fifo_data_in         (fifo_data_in),
    .fifo_not_empty_in    (fifo_not_empty_in),
    .fifo_last_in         (fifo_last_in),
    .fifo_r_stb_out       (fifo_r_stb_out),
    .chan_en_in           (chan_en_in),
    .trunc_clr_in         (trunc_clr_in),
    .grant_out            (grant_out),
    .busy_out             (busy_out),
    .pkt_done_out         (pkt_done_out),
    .trunc_err_out        (trunc_err_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic refresh_fifos();
    fifo_not_empty_in[0] = (fq0.size() != 0);
    fifo_last_in[0]      = (fq0.size() != 0) ? fq0[0].last : 1'b0;
    fifo_data_in[0 +: FW] = (fq0.size() != 0) ? fq0[0].data : '0;
    fifo_not_empty_in[1] = (fq1.size() != 0);
    fifo_last_in[1]      = (fq1.size() != 0) ? fq1[0].last : 1'b0;
    fifo_data_in[FW +: FW] = (fq1.size() != 0) ? fq1[0].data : '0;
  endtask

  // Expected beats for one source packet, including forced splits at MAXB beats.
  task automatic expect_pkt(input int unsigned ch, input int unsigned n, input logic [FW-1:0] base);
    int unsigned pos = 0;
    beat_t b;
    for (int unsigned i = 0; i < n; i++) begin
      b.data = ADW'(base + FW'(i));
      b.dest = DW'(ch);
      b.last = (i == n - 1) || (pos == MAXB - 1);
      exp_q.push_back(b);
      pos = b.last ? 0 : pos + 1;
    end
  endtask

  task automatic push_pkt(input int unsigned ch, input int unsigned n,
                          input logic [FW-1:0] base, input bit expect_it);
    word_t w;
    for (int unsigned i = 0; i < n; i++) begin
      w.data = base + FW'(i);
      w.last = (i == n - 1);
      if (ch == 0) fq0.push_back(w);
      else         fq1.push_back(w);
    end
    if (expect_it) expect_pkt(ch, n, base);
    refresh_fifos();
  endtask

  // FIFO model: pop on the strobe seen before the edge, update heads just after it.
  initial begin
    logic [NCH-1:0] stb_s;
    logic           rst_s;
    forever begin
      @(negedge clk_in);
      stb_s = fifo_r_stb_out;
      @(posedge clk_in);
      rst_s = rst_n_in;
      #1;
      if (rst_s) begin
        if (stb_s[0] && fq0.size() != 0) void'(fq0.pop_front());
        if (stb_s[1] && fq1.size() != 0) void'(fq1.pop_front());
      end
      refresh_fifos();
    end
  end

  // Output monitor: scoreboard compare, stall stability and strobe legality.
  initial begin
    beat_t ob, held, e;
    bit    held_v = 1'b0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        held_v = 1'b0;
      end else begin
        ob.data = tdata;
        ob.dest = tdest;
        ob.last = tlast;
        if (held_v) begin
          total++;
          if ({tvalid, ob} !== {1'b1, held}) begin
            bad++;
            $display("FAIL stall_hold: got v=%0b %h/%0d/%0b want v=1 %h/%0d/%0b",
                     tvalid, ob.data, ob.dest, ob.last, held.data, held.dest, held.last);
          end
        end
        total++;
        if (($countones(fifo_r_stb_out) > 1) || (|fifo_r_stb_out && tvalid && !tready)) begin
          bad++;
          $display("FAIL stb_legal: got stb=%b tvalid=%0b tready=%0b want no pop into full register",
                   fifo_r_stb_out, tvalid, tready);
        end
        if (tvalid && tready) begin
          total++;
          acc_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got %h/%0d/%0b want no beat", ob.data, ob.dest, ob.last);
          end else begin
            e = exp_q.pop_front();
            if (ob !== e) begin
              bad++;
              $display("FAIL beat: got data=%h dest=%0d last=%0b want data=%h dest=%0d last=%0b",
                       ob.data, ob.dest, ob.last, e.data, e.dest, e.last);
            end
          end
        end
        if (pkt_done_out) done_cnt++;
        held_v = tvalid && !tready;
        held   = ob;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(input int unsigned budget);
    bit ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !tvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got %0d beats pending want 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n_in = 1'b0;
    fq0.delete();
    fq1.delete();
    exp_q.delete();
    acc_cyc.delete();
    tready       = 1'b1;
    chan_en_in   = '1;
    trunc_clr_in = '0;
    refresh_fifos();
    repeat (3) step();
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2;
    rst_n_in = 1'b0;
    step();
    total++;
    if ({tvalid, tlast, tdata, tdest} !== '0) begin
      bad++;
      $display("FAIL reset_stream: got v=%0b l=%0b d=%h dest=%0d want all 0", tvalid, tlast, tdata, tdest);
    end
    total++;
    if ({fifo_r_stb_out, grant_out, busy_out, pkt_done_out, trunc_err_out} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got stb=%b gnt=%b busy=%0b done=%0b trunc=%b want all 0",
               fifo_r_stb_out, grant_out, busy_out, pkt_done_out, trunc_err_out);
    end
    total++;
    if (tkeep !== '1 || tuser !== 1'b0) begin
      bad++;
      $display("FAIL const_sideband: got keep=%h user=%0b want keep=f user=0", tkeep, tuser);
    end
    do_reset();
  endtask

  task automatic test_single_packet();
    int unsigned d0 = done_cnt;
    acc_cyc.delete();
    push_pkt(0, 4, 16'h1000, 1'b1);
    wait_drain(50);
    total++;
    if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 3) begin
      bad++;
      $display("FAIL single_rate: got %0d beats over span %0d want 4 beats span 3",
               acc_cyc.size(), (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[0] : 0);
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0);
    end
  endtask

  task automatic test_two_channels();
    do_reset();
    push_pkt(0, 3, 16'h2000, 1'b1);
    push_pkt(1, 3, 16'h3000, 1'b1);
    wait_drain(60);
    total++;
    if (acc_cyc.size() != 6 || acc_cyc[2] - acc_cyc[0] != 2 || acc_cyc[3] - acc_cyc[2] != 2) begin
      bad++;
      $display("FAIL two_ch_timing: got %0d beats want 6 with one idle cycle between packets",
               acc_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pat = 16'b1111_1110_1001_0111;
    int unsigned d0 = done_cnt;
    push_pkt(0, 4, 16'h4000, 1'b1);
    for (int unsigned i = 0; i < 16; i++) begin
      tready = pat[i];
      step();
    end
    tready = 1'b1;
    wait_drain(50);
    total++;
    if (done_cnt - d0 != 1 || trunc_err_out !== 2'b00) begin
      bad++;
      $display("FAIL bp_done: got done=%0d trunc=%b want done=1 trunc=00", done_cnt - d0, trunc_err_out);
    end
  endtask

  task automatic test_truncation();
    int unsigned d0 = done_cnt;
    push_pkt(1, 6, 16'h5000, 1'b1);
    wait_drain(60);
    total++;
    if (trunc_err_out !== 2'b10 || done_cnt - d0 != 2) begin
      bad++;
      $display("FAIL trunc_set: got trunc=%b done=%0d want trunc=10 done=2", trunc_err_out, done_cnt - d0);
    end
    trunc_clr_in = 2'b10;
    step();
    trunc_clr_in = 2'b00;
    total++;
    if (trunc_err_out !== 2'b00) begin
      bad++;
      $display("FAIL trunc_clr: got %b want 00", trunc_err_out);
    end
  endtask

  task automatic test_enable_mask();
    bit seen = 1'b0;
    acc_cyc.delete();
    chan_en_in = 2'b10;
    push_pkt(0, 3, 16'h6000, 1'b0);
    push_pkt(1, 3, 16'h7000, 1'b1);
    for (int unsigned i = 0; i < 30; i++) begin
      if (acc_cyc.size() != 0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL en_first_beat: got no beat want beat within 30 cycles");
    end
    chan_en_in = 2'b00;
    wait_drain(40);
    repeat (5) step();
    total++;
    if (grant_out !== 2'b00 || fq0.size() != 3) begin
      bad++;
      $display("FAIL en_masked: got grant=%b ch0_left=%0d want grant=00 ch0_left=3", grant_out, fq0.size());
    end
    chan_en_in = 2'b11;
    expect_pkt(0, 3, 16'h6000);
    wait_drain(40);
  endtask

  task automatic test_back_to_back();
    acc_cyc.delete();
    push_pkt(0, 2, 16'h8000, 1'b1);
    push_pkt(0, 2, 16'h8100, 1'b1);
    wait_drain(50);
    total++;
    if (acc_cyc.size() != 4 || acc_cyc[1] - acc_cyc[0] != 1 ||
        acc_cyc[2] - acc_cyc[1] != 2 || acc_cyc[3] - acc_cyc[2] != 1) begin
      bad++;
      $display("FAIL regrant_gap: got %0d beats want 4 with gaps 1,2,1", acc_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    tready = 1'b0;
    push_pkt(0, 3, 16'h9000, 1'b0);
    for (int unsigned i = 0; i < 20; i++) begin
      if (tvalid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!seen || !busy_out) begin
      bad++;
      $display("FAIL rst_mid_setup: got tvalid=%0b busy=%0b want 1/1", tvalid, busy_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if ({tvalid, tlast, busy_out, grant_out, fifo_r_stb_out, tdata} !== '0) begin
      bad++;
      $display("FAIL rst_async: got v=%0b l=%0b busy=%0b gnt=%b stb=%b d=%h want all 0",
               tvalid, tlast, busy_out, grant_out, fifo_r_stb_out, tdata);
    end
    fq0.delete();
    fq1.delete();
    exp_q.delete();
    tready = 1'b1;
    refresh_fifos();
    repeat (2) step();
    rst_n_in = 1'b1;
    step();
    push_pkt(0, 2, 16'hB000, 1'b1);
    push_pkt(1, 2, 16'hA000, 1'b1);
    wait_drain(50);
  endtask

  initial begin
    refresh_fifos();
    test_reset();
    test_single_packet();
    test_two_channels();
    test_backpressure();
    test_truncation();
    test_enable_mask();
    test_back_to_back();
    test_reset_mid();
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
